// File: rtl/i2c_target_regs_pkg.sv
// Shared definitions for the I2C target register window: FSM state encoding,
// default bus address and the address-match helper.
package i2c_target_regs_pkg;

  localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h42;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_ADDR     = 4'd1,
    ST_ADDR_ACK = 4'd2,
    ST_PTR      = 4'd3,
    ST_WDATA    = 4'd4,
    ST_WACK     = 4'd5,
    ST_RDATA    = 4'd6,
    ST_RACK     = 4'd7,
    ST_IGNORE   = 4'd8
  } i2c_state_e;

  // Address byte is {addr[6:0], r/w}; only the upper seven bits select us.
  function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] target);
    return addr_byte[7:1] == target;
  endfunction

endpackage

// File: rtl/i2c_target_regs_filter.sv
// Input conditioning for one open-drain bus line: a two-flop synchroniser
// followed by a stability counter, so a level is only accepted once it has
// been seen for FILTER_LEN consecutive clocks. Idle bus level is high.
module i2c_input_filter #(
  parameter int FILTER_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the accepted level.
  always_comb begin
    meta_d  = din;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, accepted level and stability counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-wide register window with an auto-incrementing
// pointer. 7-bit addressing, no clock stretching. Write transfers set the
// pointer with the first byte and then write data; read transfers stream
// bytes from the pointer until the master NACKs.
module i2c_target_regs
  import i2c_target_regs_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
  parameter int         PTR_BITS    = 3,
  parameter int         FILTER_LEN  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  output logic [PTR_BITS-1:0] reg_addr,
  output logic [7:0]          reg_wdata,
  output logic                reg_we,
  input  logic [7:0]          reg_rdata,
  output logic                reg_rd,
  output logic                busy
);

  logic scl_f, sda_f;

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filter (
    .clk   (clk),
    .reset (reset),
    .din   (scl_in),
    .dout  (scl_f)
  );

  i2c_input_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filter (
    .clk   (clk),
    .reset (reset),
    .din   (sda_in),
    .dout  (sda_f)
  );

  i2c_state_e          state_q, state_d;
  logic [7:0]          sr_q, sr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PTR_BITS-1:0] ptr_q, ptr_d;
  logic                sda_oe_q, sda_oe_d;
  logic                busy_q, busy_d;
  logic                reg_we_q, reg_we_d;
  logic [7:0]          reg_wdata_q, reg_wdata_d;
  logic                reg_rd_q, reg_rd_d;
  logic                scl_dly_q, scl_dly_d;
  logic                sda_dly_q, sda_dly_d;

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;

  // Edge events on the filtered lines; SDA moving while SCL was high is a bus
  // condition and takes priority over a coincident SCL edge.
  always_comb begin
    scl_rise = scl_f & ~scl_dly_q;
    scl_fall = ~scl_f & scl_dly_q;
    sda_rise = sda_f & ~sda_dly_q;
    sda_fall = ~sda_f & sda_dly_q;
    start_c  = sda_fall & scl_dly_q;
    stop_c   = sda_rise & scl_dly_q;
  end

  // Protocol FSM: shift register, bit counter, pointer and SDA drive.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    reg_we_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;
    reg_rd_d    = 1'b0;
    scl_dly_d   = scl_f;
    sda_dly_d   = sda_f;

    // The pointer advances the cycle after a write strobe, so the host sees
    // the write at the old address.
    if (reg_we_q) begin
      ptr_d = ptr_q + 1'b1;
    end

    if (stop_c) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (start_c) begin
      state_d  = ST_ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = '0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_f};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (addr_match(sr_q, TARGET_ADDR)) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ST_ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sr_q[0]) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_PTR;
            end else begin
              // First read byte comes from the current pointer.
              sr_d     = reg_rdata;
              sda_oe_d = ~reg_rdata[7];
              reg_rd_d = 1'b1;
              cnt_d    = 4'd1;
              state_d  = ST_RDATA;
            end
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_f};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            ptr_d    = sr_q[PTR_BITS-1:0];
            sda_oe_d = 1'b1;
            state_d  = ST_WACK;
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            sr_d  = {sr_q[6:0], sda_f};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              reg_we_d    = 1'b1;
              reg_wdata_d = {sr_q[6:0], sda_f};
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_oe_d = 1'b1;
            state_d  = ST_WACK;
          end
        end
        ST_WACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = ST_WDATA;
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = ST_RACK;
            end else begin
              sr_d     = {sr_q[6:0], 1'b0};
              sda_oe_d = ~sr_q[6];
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        ST_RACK: begin
          // cnt_q marks that the master has ACKed and the next byte is due.
          if (scl_rise) begin
            if (!sda_f) begin
              ptr_d = ptr_q + 1'b1;
              cnt_d = 4'd1;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            sr_d     = reg_rdata;
            sda_oe_d = ~reg_rdata[7];
            reg_rd_d = 1'b1;
            cnt_d    = 4'd1;
            state_d  = ST_RDATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // State and datapath registers; the reset releases SDA asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_wdata_q <= '0;
      reg_rd_q    <= 1'b0;
      scl_dly_q   <= 1'b1;
      sda_dly_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      reg_rd_q    <= reg_rd_d;
      scl_dly_q   <= scl_dly_d;
      sda_dly_q   <= sda_dly_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = ptr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_rd    = reg_rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master on a wired-AND SDA line,
// a register model returning 0x30+addr, and a write scoreboard.
module tb_i2c_target_regs;

  localparam int QTR = 10;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_in;
  logic       sda_m;
  logic       sda_in;
  logic       sda_oe;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic [7:0] reg_rdata;
  logic       reg_rd;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [10:0] exp_q[$];   // expected {addr, data} writes
  logic [10:0] we_log[$];  // observed writes, appended by the monitor
  int          we_idx = 0;
  int          rd_count = 0;
  int          oe_cycles = 0;

  assign sda_in    = sda_m & ~sda_oe;
  assign reg_rdata = 8'h30 + {5'd0, reg_addr};

  always #5 clk = ~clk;

  i2c_target_regs #(.TARGET_ADDR(7'h42), .PTR_BITS(3), .FILTER_LEN(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_rdata (reg_rdata),
    .reg_rd    (reg_rd),
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (reg_we) we_log.push_back({reg_addr, reg_wdata});
    if (reg_rd) rd_count++;
    if (sda_oe) oe_cycles++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wq();
    repeat (QTR) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq();
    scl_in = 1'b1; wq();
    sda_m = 1'b0; wq();
    scl_in = 1'b0; wq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq();
    scl_in = 1'b1; wq();
    sda_m = 1'b1; wq();
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    sda_m = b; wq();
    scl_in = 1'b1; wq();
    if (glitch) begin
      sda_m = ~b;
      @(negedge clk);
      sda_m = b;
    end
    wq();
    scl_in = 1'b0; wq();
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; wq();
    scl_in = 1'b1; wq();
    b = sda_in; wq();
    scl_in = 1'b0; wq();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic [7:0] gmask, output logic ack_n);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gmask[i]);
    recv_bit(ack_n);
  endtask

  task automatic recv_byte(input logic ack_n, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack_n, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; scl_in = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rst_sda_oe: got %b, expected 0", sda_oe); end
    checks++; if (reg_addr !== 3'd0) begin errors++; $display("FAIL rst_reg_addr: got %0d, expected 0", reg_addr); end
    checks++; if (reg_wdata !== 8'h00) begin errors++; $display("FAIL rst_reg_wdata: got %02h, expected 00", reg_wdata); end
    checks++; if (reg_we !== 1'b0) begin errors++; $display("FAIL rst_reg_we: got %b, expected 0", reg_we); end
    checks++; if (reg_rd !== 1'b0) begin errors++; $display("FAIL rst_reg_rd: got %b, expected 0", reg_rd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    reset = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_write_basic();
    logic ack_n;
    logic [10:0] e;
    logic [7:0] bytes [4] = '{8'h84, 8'h02, 8'hA5, 8'h5A};
    exp_q.push_back({3'd2, 8'hA5});
    exp_q.push_back({3'd3, 8'h5A});
    bus_start();
    for (int k = 0; k < 4; k++) begin
      send_byte(bytes[k], 8'h00, ack_n);
      checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL wr_ack%0d: got %b, expected 0", k, ack_n); end
      if (k == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b, expected 1", busy); end
      end
    end
    bus_stop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (we_idx >= we_log.size()) begin errors++; $display("FAIL wr_missing: got none, expected %03h", e); end
      else begin
        if (we_log[we_idx] !== e) begin errors++; $display("FAIL wr_data: got %03h, expected %03h", we_log[we_idx], e); end
        we_idx++;
      end
    end
    checks++; if (we_log.size() != we_idx) begin errors++; $display("FAIL wr_extra: got %0d writes, expected %0d", we_log.size(), we_idx); end
    we_idx = we_log.size();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end: got %b, expected 0", busy); end
    checks++; if (reg_addr !== 3'd4) begin errors++; $display("FAIL wr_ptr_end: got %0d, expected 4", reg_addr); end
  endtask

  task automatic test_write_wrap();
    logic ack_n;
    logic [10:0] e;
    logic [7:0] bytes [4] = '{8'h84, 8'h07, 8'h11, 8'h22};
    exp_q.push_back({3'd7, 8'h11});
    exp_q.push_back({3'd0, 8'h22});
    bus_start();
    for (int k = 0; k < 4; k++) begin
      send_byte(bytes[k], 8'h00, ack_n);
      checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL wrap_ack%0d: got %b, expected 0", k, ack_n); end
    end
    bus_stop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (we_idx >= we_log.size()) begin errors++; $display("FAIL wrap_missing: got none, expected %03h", e); end
      else begin
        if (we_log[we_idx] !== e) begin errors++; $display("FAIL wrap_data: got %03h, expected %03h", we_log[we_idx], e); end
        we_idx++;
      end
    end
    checks++; if (we_log.size() != we_idx) begin errors++; $display("FAIL wrap_extra: got %0d writes, expected %0d", we_log.size(), we_idx); end
    we_idx = we_log.size();
    checks++; if (reg_addr !== 3'd1) begin errors++; $display("FAIL wrap_ptr: got %0d, expected 1", reg_addr); end
  endtask

  task automatic test_read_repeated();
    logic ack_n;
    logic [7:0] d;
    logic [7:0] e;
    logic [7:0] rd_exp_q[$];
    int rd_base;
    rd_exp_q.push_back(8'h34);
    rd_exp_q.push_back(8'h35);
    rd_exp_q.push_back(8'h36);
    rd_base = rd_count;
    bus_start();
    send_byte(8'h84, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL rd_ack_waddr: got %b, expected 0", ack_n); end
    send_byte(8'h04, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL rd_ack_ptr: got %b, expected 0", ack_n); end
    bus_start();
    send_byte(8'h85, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL rd_ack_raddr: got %b, expected 0", ack_n); end
    for (int k = 0; k < 3; k++) begin
      recv_byte((k == 2) ? 1'b1 : 1'b0, d);
      e = rd_exp_q.pop_front();
      checks++; if (d !== e) begin errors++; $display("FAIL rd_byte%0d: got %02h, expected %02h", k, d, e); end
    end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rd_nack_oe: got %b, expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_nack_busy: got %b, expected 0", busy); end
    bus_stop();
    checks++; if (rd_count - rd_base != 3) begin errors++; $display("FAIL rd_pulses: got %0d, expected 3", rd_count - rd_base); end
    checks++; if (we_log.size() != we_idx) begin errors++; $display("FAIL rd_no_write: got %0d writes, expected %0d", we_log.size(), we_idx); end
    we_idx = we_log.size();
    checks++; if (reg_addr !== 3'd6) begin errors++; $display("FAIL rd_ptr: got %0d, expected 6", reg_addr); end
  endtask

  task automatic test_other_addr();
    logic ack_n;
    int rd_base, oe_base;
    rd_base = rd_count;
    oe_base = oe_cycles;
    bus_start();
    send_byte(8'h90, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b1) begin errors++; $display("FAIL oth_addr_ack: got %b, expected 1", ack_n); end
    send_byte(8'h12, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b1) begin errors++; $display("FAIL oth_data_ack: got %b, expected 1", ack_n); end
    bus_stop();
    checks++; if (oe_cycles != oe_base) begin errors++; $display("FAIL oth_oe: got %0d driven cycles, expected 0", oe_cycles - oe_base); end
    checks++; if (we_log.size() != we_idx) begin errors++; $display("FAIL oth_we: got %0d writes, expected %0d", we_log.size(), we_idx); end
    we_idx = we_log.size();
    checks++; if (rd_count != rd_base) begin errors++; $display("FAIL oth_rd: got %0d pulses, expected 0", rd_count - rd_base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL oth_busy: got %b, expected 0", busy); end
    checks++; if (reg_addr !== 3'd6) begin errors++; $display("FAIL oth_ptr: got %0d, expected 6", reg_addr); end
  endtask

  task automatic test_glitch_abort();
    logic ack_n;
    logic [10:0] e;
    exp_q.push_back({3'd1, 8'hC3});
    bus_start();
    send_byte(8'h84, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL gl_ack_addr: got %b, expected 0", ack_n); end
    send_byte(8'h01, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL gl_ack_ptr: got %b, expected 0", ack_n); end
    // glitches while SCL high: false START on bit 7, false STOP on bit 5
    send_byte(8'hC3, 8'hA0, ack_n);
    checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL gl_ack_data: got %b, expected 0", ack_n); end
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    bus_stop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (we_idx >= we_log.size()) begin errors++; $display("FAIL gl_missing: got none, expected %03h", e); end
      else begin
        if (we_log[we_idx] !== e) begin errors++; $display("FAIL gl_data: got %03h, expected %03h", we_log[we_idx], e); end
        we_idx++;
      end
    end
    checks++; if (we_log.size() != we_idx) begin errors++; $display("FAIL gl_partial_we: got %0d writes, expected %0d", we_log.size(), we_idx); end
    we_idx = we_log.size();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gl_busy: got %b, expected 0", busy); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL gl_oe: got %b, expected 0", sda_oe); end
    checks++; if (reg_addr !== 3'd2) begin errors++; $display("FAIL gl_ptr: got %0d, expected 2", reg_addr); end
  endtask

  task automatic test_reset_mid();
    logic ack_n;
    logic [10:0] e;
    logic [7:0] addr_b = 8'h84;
    bit seen = 1'b0;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(addr_b[i], 1'b0);
    sda_m = 1'b1;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clk);
      if (sda_oe === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rm_ack_timeout: got sda_oe=%b, expected 1 within 40 clks", sda_oe); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL rm_oe_async: got %b, expected 0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b, expected 0", busy); end
    checks++; if (reg_addr !== 3'd0) begin errors++; $display("FAIL rm_ptr: got %0d, expected 0", reg_addr); end
    repeat (3) @(negedge clk);
    scl_in = 1'b1;
    sda_m = 1'b1;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (we_log.size() != we_idx) begin errors++; $display("FAIL rm_partial_we: got %0d writes, expected %0d", we_log.size(), we_idx); end
    we_idx = we_log.size();
    exp_q.push_back({3'd5, 8'h77});
    bus_start();
    send_byte(8'h84, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL rm_ack_addr: got %b, expected 0", ack_n); end
    send_byte(8'h05, 8'h00, ack_n);
    send_byte(8'h77, 8'h00, ack_n);
    checks++; if (ack_n !== 1'b0) begin errors++; $display("FAIL rm_ack_data: got %b, expected 0", ack_n); end
    bus_stop();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (we_idx >= we_log.size()) begin errors++; $display("FAIL rm_missing: got none, expected %03h", e); end
      else begin
        if (we_log[we_idx] !== e) begin errors++; $display("FAIL rm_data: got %03h, expected %03h", we_log[we_idx], e); end
        we_idx++;
      end
    end
    checks++; if (reg_addr !== 3'd6) begin errors++; $display("FAIL rm_ptr_end: got %0d, expected 6", reg_addr); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_wrap();
    test_read_repeated();
    test_other_addr();
    test_glitch_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
